// File: rtl/serial_add_seq_if.sv
// Operand and result handshakes for serial_add_seq.
// The master side supplies operands and drains results; the slave is the sequencer.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic             i_cin;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             o_busy;

    modport master (
        output i_valid, i_op_a, i_op_b, i_cin, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_busy
    );

    modport slave (
        input  i_valid, i_op_a, i_op_b, i_cin, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf, o_busy
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer driving an external registered 1-bit full adder,
// LSB first, and reassembling sum, carry-out and signed overflow.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    serial_add_seq_if.slave  bus,
    output logic             o_fa_a,
    output logic             o_fa_b,
    output logic             o_fa_c,
    input  logic             i_fa_o,
    input  logic             i_fa_c
);
    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH);
    localparam logic [KW-1:0] K_MSB  = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic             cin0_reg;
    logic             cmsb_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // The adder's sum for bit k-1 arrives while the counter reads k.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_acc
            assign acc_next[gi] = (k_reg == KW'(gi + 1)) ? i_fa_o : acc_reg[gi];
        end
    endgenerate

    // Operands shift right each RUN cycle so bit 0 is always the current bit.
    always_comb begin
        o_fa_a = 1'b0;
        o_fa_b = 1'b0;
        o_fa_c = 1'b0;
        if (state_reg == RUN && k_reg != K_LAST) begin
            o_fa_a = a_reg[0];
            o_fa_b = b_reg[0];
            o_fa_c = (k_reg == '0) ? cin0_reg : i_fa_c;
        end
    end

    assign bus.o_ready = (state_reg == IDLE) && i_reset;
    assign bus.o_valid = (state_reg == DONE);
    assign bus.o_busy  = (state_reg != IDLE);
    assign bus.o_sum   = sum_reg;
    assign bus.o_cout  = cout_reg;
    assign bus.o_ovf   = ovf_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            cin0_reg  <= 1'b0;
            cmsb_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_valid) begin
                        a_reg     <= bus.i_op_a;
                        b_reg     <= bus.i_sub ? ~bus.i_op_b : bus.i_op_b;
                        cin0_reg  <= bus.i_sub | bus.i_cin;
                        k_reg     <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    if (k_reg == K_MSB) begin
                        cmsb_reg <= o_fa_c;
                    end
                    if (k_reg == K_LAST) begin
                        cout_reg  <= i_fa_c;
                        ovf_reg   <= cmsb_reg ^ i_fa_c;
                        sum_reg   <= acc_next;
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.i_valid && bus.i_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: behavioural full adder, directed cases and random ops
// against an arithmetic reference model.
module tb_serial_add_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic fa_a, fa_b, fa_c, fa_o, fa_co;
    int   total = 0;
    int   bad   = 0;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave),
        .o_fa_a  (fa_a),
        .o_fa_b  (fa_b),
        .o_fa_c  (fa_c),
        .i_fa_o  (fa_o),
        .i_fa_c  (fa_co)
    );

    always #5 clk = ~clk;

    // Registered full adder, reset active-high from ~rst_n.
    always @(posedge clk) begin
        if (!rst_n) begin
            fa_o  <= 1'b0;
            fa_co <= 1'b0;
        end else begin
            {fa_co, fa_o} <= 2'(fa_a) + 2'(fa_b) + 2'(fa_c);
        end
    end

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
        logic [W-1:0] bb;
        int c, u, s, sa, sb;
        logic [W-1:0] sum;
        logic cout, ovf;
        bb  = sub ? ~b : b;
        c   = (sub || cin) ? 1 : 0;
        u   = int'(a) + int'(bb) + c;
        sa  = $signed(a);
        sb  = $signed(bb);
        s   = sa + sb + c;
        sum = u[W-1:0];
        cout = (u > 255);
        ovf  = (s > 127) || (s < -128);
        return {ovf, cout, sum};
    endfunction

    // Runs one operation; returns observed result and latency (edges from accept to o_valid).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int stall, output logic [W-1:0] s,
                         output logic co, output logic ov, output int lat);
        int n;
        n = 0;
        while (!bus.o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        bus.i_op_a  = a;
        bus.i_op_b  = b;
        bus.i_cin   = cin;
        bus.i_sub   = sub;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        s  = bus.o_sum;
        co = bus.o_cout;
        ov = bus.o_ovf;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.o_ready); end
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
        total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.o_busy); end
        total++; if ({bus.o_sum, bus.o_cout, bus.o_ovf} !== 10'h0) begin bad++; $display("FAIL reset_result got=%h/%b/%b want=0", bus.o_sum, bus.o_cout, bus.o_ovf); end
        total++; if ({fa_a, fa_b, fa_c} !== 3'b000) begin bad++; $display("FAIL reset_fa got=%b want=000", {fa_a, fa_b, fa_c}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.o_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7] = '{8'h35, 8'hFF, 8'h7F, 8'h00, 8'h10, 8'h80, 8'h10};
        logic [W-1:0] vb [7] = '{8'h4A, 8'h01, 8'h01, 8'h00, 8'h20, 8'h01, 8'h20};
        logic         vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         vs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] es [7] = '{8'h7F, 8'h00, 8'h80, 8'h01, 8'hF0, 8'h7F, 8'hF0};
        logic         ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vc[i], vs[i], 0, s, co, ov, lat);
            $display("directed %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, va[i], vb[i], vc[i], vs[i], s, co, ov, lat);
            total++; if (s !== es[i]) begin bad++; $display("FAIL dir_sum[%0d] got=%h want=%h", i, s, es[i]); end
            total++; if (co !== ec[i]) begin bad++; $display("FAIL dir_cout[%0d] got=%b want=%b", i, co, ec[i]); end
            total++; if (ov !== eo[i]) begin bad++; $display("FAIL dir_ovf[%0d] got=%b want=%b", i, ov, eo[i]); end
            total++; if (lat !== W + 1) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, W + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s;
        logic co, ov;
        int n, lat;
        bus.i_op_a = 8'h12; bus.i_op_b = 8'h34; bus.i_cin = 1'b0; bus.i_sub = 1'b0;
        bus.i_ready = 1'b0; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        total++; if (n !== W + 1) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", n, W + 1); end
        for (int c = 0; c < 5; c++) begin
            bus.i_valid = (c == 2);
            bus.i_op_a  = 8'hAA;
            bus.i_op_b  = 8'h55;
            @(posedge clk); #1;
            total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", c, bus.o_valid); end
            total++; if (bus.o_sum !== 8'h46 || bus.o_cout !== 1'b0 || bus.o_ovf !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b/%b want=46/0/0", c, bus.o_sum, bus.o_cout, bus.o_ovf); end
            total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", c, bus.o_ready); end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        $display("backpressure: held 5 cycles sum=%h, released", bus.o_sum);
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", bus.o_ready); end
        do_op(8'hC3, 8'h3C, 1'b1, 1'b0, 0, s, co, ov, lat);
        $display("back_to_back: C3+3C+1 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        total++; if ({ov, co, s} !== {1'b0, 1'b1, 8'h00}) begin bad++; $display("FAIL b2b_result got=%b/%b/%h want=0/1/00", ov, co, s); end
        total++; if (lat !== W + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, W + 1); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s;
        logic co, ov;
        int lat, seen;
        bus.i_op_a = 8'h0F; bus.i_op_b = 8'h0F; bus.i_cin = 1'b0; bus.i_sub = 1'b0;
        bus.i_ready = 1'b1; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got busy=%b valid=%b ready=%b want 0/0/0", bus.o_busy, bus.o_valid, bus.o_ready); end
        total++; if ({bus.o_sum, bus.o_cout, bus.o_ovf, fa_a, fa_b, fa_c} !== 13'h0) begin bad++; $display("FAIL midrst_outputs got sum=%h cout=%b ovf=%b fa=%b want 0", bus.o_sum, bus.o_cout, bus.o_ovf, {fa_a, fa_b, fa_c}); end
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.o_valid) seen++;
        end
        bus.i_ready = 1'b0;
        $display("reset_mid_run: o_valid cycles after abort=%0d", seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d want=0", seen); end
        do_op(8'h01, 8'h02, 1'b0, 1'b0, 0, s, co, ov, lat);
        $display("after_reset: 01+02 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        total++; if ({ov, co, s} !== {1'b0, 1'b0, 8'h03}) begin bad++; $display("FAIL midrst_next got=%b/%b/%h want=0/0/03", ov, co, s); end
        total++; if (lat !== W + 1) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, W + 1); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic cin, sub, co, ov;
        logic [W+1:0] exp;
        int lat, stall;
        for (int i = 0; i < 1000; i++) begin
            a     = W'($urandom_range(0, 255));
            b     = W'($urandom_range(0, 255));
            cin   = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            exp   = ref_model(a, b, cin, sub);
            do_op(a, b, cin, sub, stall, s, co, ov, lat);
            $display("rand %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", i, a, b, cin, sub, s, co, ov);
            total++; if (s !== exp[W-1:0]) begin bad++; $display("FAIL rand_sum[%0d] got=%h want=%h", i, s, exp[W-1:0]); end
            total++; if (co !== exp[W]) begin bad++; $display("FAIL rand_cout[%0d] got=%b want=%b", i, co, exp[W]); end
            total++; if (ov !== exp[W+1]) begin bad++; $display("FAIL rand_ovf[%0d] got=%b want=%b", i, ov, exp[W+1]); end
            total++; if (lat !== W + 1) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, W + 1); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_op_a  = '0;
        bus.i_op_b  = '0;
        bus.i_cin   = 1'b0;
        bus.i_sub   = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add/subtract sequencer wrapped around one registered 1-bit full-adder stage (`i_a`/`i_b`/`i_c` in, `o_o`/`o_c` out, one-clock latency). It accepts WIDTH-bit operand pairs over a valid/ready handshake and feeds them to the full-adder stage one bit per cycle, LSB first. It routes the adder's registered carry back into the next bit, reassembles the sum, and presents sum, carry-out and signed overflow downstream on a second valid/ready handshake. It is the ALU arithmetic path's front/back end for the bit-adder stage.

## Interface

Parameters:
- WIDTH, 8, operand/sum width in bits (≥2).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_valid  in  1  operand pair present.
- o_ready  out  1  block can accept operands.
- i_op_a  in  WIDTH  operand A.
- i_op_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in (add mode only).
- i_sub  in  1  1 = A − B (B inverted, carry-in forced 1; i_cin ignored).
- o_fa_a  out  1  bit to full-adder `i_a`.
- o_fa_b  out  1  bit to full-adder `i_b`.
- o_fa_c  out  1  carry to full-adder `i_c`.
- i_fa_o  in  1  full-adder registered sum `o_o`.
- i_fa_c  in  1  full-adder registered carry `o_c`.
- o_valid  out  1  result present.
- i_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry-out; in subtract mode 1 = no borrow.
- o_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- o_busy  out  1  state != IDLE.

Integration: the full-adder instance shares i_clk; its active-high reset is driven by ~i_reset.

## Operation

- States: IDLE, RUN, DONE. Bit counter k is 0..WIDTH, $clog2(WIDTH+1) bits.
- IDLE: o_ready=1.
  - On i_valid & o_ready, latch A, B' = i_sub ? ~i_op_b : i_op_b, and cin0 = i_sub | i_cin.
  - Set k=0 and go to RUN.
- RUN, cycle k (combinational drive):
  - k<WIDTH: o_fa_a=A[k], o_fa_b=B'[k].
  - o_fa_c = cin0 when k=0, else i_fa_c (direct pass-through of the previous bit's registered carry).
  - k=WIDTH: o_fa_a/b/c=0.
- RUN, edge ending cycle k:
  - k≥1: sum[k-1] ← i_fa_o.
  - k=WIDTH−1: cmsb ← o_fa_c.
  - k=WIDTH: o_cout ← i_fa_c, o_ovf ← cmsb ^ i_fa_c, o_sum ← assembled sum, go to DONE.
  - Otherwise k ← k+1.
- DONE: o_valid=1. o_sum/o_cout/o_ovf are stable. On i_valid=0, i_ready=1 go to IDLE.
- Outside RUN, o_fa_a/b/c=0.
- o_ready=0 in RUN and DONE. i_valid is ignored there and there is no operand queueing.
- Results hold their last value after the output handshake until the next completion.
- Arithmetic is modulo 2^WIDTH; o_sum is never wider than WIDTH.

## Timing

- Reset (i_reset=0 at an edge): state IDLE, k=0, o_sum=0, o_cout=0, o_ovf=0, o_valid=0, o_busy=0, o_fa_*=0.
- o_ready is forced 0 while i_reset=0.
- Reset mid-RUN or in DONE aborts the operation; no o_valid follows. The first accept after release works normally.
- Latency: with the accept edge at E, o_valid=1 from edge E+WIDTH+1 (9 cycles for WIDTH=8). Throughput is one operation per WIDTH+3 cycles with i_ready held high.
- The output handshake edge sets o_ready=1 in the very next cycle.
- o_fa_c depends combinationally on i_fa_c. This path is legal only because the full adder's outputs are registered.

## Test plan

- Add, WIDTH=8: 0x35 + 0x4A, cin=0 → o_sum=0x7F, o_cout=0, o_ovf=0; o_valid rises exactly 9 edges after accept.
- Add wrap: 0xFF + 0x01 → 0x00, cout=1, ovf=0. Signed overflow: 0x7F + 0x01 → 0x80, cout=0, ovf=1. Carry-in: 0x00 + 0x00 with cin=1 → 0x01.
- Subtract: 0x10 − 0x20 → 0xF0, cout=0, ovf=0. Subtract: 0x80 − 0x01 → 0x7F, cout=1, ovf=1. Check that i_cin=0 is ignored.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o_valid stays 1, outputs stable, o_ready=0, an i_valid pulse with new operands is not taken. Raise i_ready → o_ready=1 the next cycle; a back-to-back operation completes correctly.
- Reset mid-RUN: drive i_reset=0 at k=4 → all outputs 0 on the next edge, no o_valid ever appears for that operation. After release, 0x01 + 0x02 → 0x03.
- Randomised 1000 ops, random i_sub/i_cin/i_ready stalls → o_sum/o_cout/o_ovf match a reference model every time.
